// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants, types and helpers for the parametrised
//               integer register file with busy-bit scoreboard.
// Contents    : DEF_XLEN / DEF_NREG / DEF_NRD defaults, addr_width() helper,
//               reg_idx_t index type, ZERO_REG hardwired-zero index.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;
    localparam int DEF_NRD  = 2;

    // Address width needed to index n registers (n is a power of two >= 2).
    function automatic int addr_width(input int n);
        return $clog2(n);
    endfunction

    typedef logic [$clog2(DEF_NREG)-1:0] reg_idx_t;

    // Register index that always reads zero and can never become busy.
    localparam int ZERO_REG = 0;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Busy-bit vector with set (issue), clear (writeback) and flush,
//               plus an incrementally maintained count of busy registers.
// Ports       : clk, rst       - clock, asynchronous active-high reset
//               set_en/set_idx - mark a register pending (issue)
//               clr_en/clr_idx - retire a register (writeback)
//               flush          - clear every busy bit (wins over set)
//               busy           - busy vector, bit 0 is always 0
//               busy_cnt       - number of busy registers
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    parameter int AW   = addr_width(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en,
    input  logic [AW-1:0]   set_idx,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_idx,
    input  logic            flush,
    output logic [NREG-1:0] busy,
    output logic [AW:0]     busy_cnt
);

    logic [NREG-1:0] r_busy;
    logic [AW:0]     r_cnt;
    logic [NREG-1:0] w_busy_nxt;
    logic            w_set;
    logic            w_clr;
    logic            w_inc;
    logic            w_dec;

    // Register 0 can never be set or cleared, so its bit stays 0 from reset.
    assign w_set = set_en && (set_idx != AW'(ZERO_REG));
    assign w_clr = clr_en && (clr_idx != AW'(ZERO_REG));

    // A new issue supersedes a retiring write to the same register.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_clr) begin
            w_busy_nxt[clr_idx] = 1'b0;
        end
        if (w_set) begin
            w_busy_nxt[set_idx] = 1'b1;
        end
    end

    // Count only real transitions so the counter tracks popcount exactly.
    assign w_inc = w_set && !r_busy[set_idx];
    assign w_dec = w_clr && r_busy[clr_idx] && !(w_set && (set_idx == clr_idx));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else if (flush) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= r_cnt + (AW+1)'(w_inc) - (AW+1)'(w_dec);
        end
    end

    assign busy     = r_busy;
    assign busy_cnt = r_cnt;

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Parametrised register file (hardwired-zero x0) with NRD
//               combinational read ports and an integrated busy scoreboard
//               for RAW hazard detection at decode.
// Ports       : clk, rst           - clock, asynchronous active-high reset
//               rs / rv / rbusy    - per-port read address, data, busy flag
//               we / rd / indata   - writeback port
//               issue_en/issue_rd  - mark destination of issued instruction
//               sb_clr             - flush all busy bits
//               busy_cnt           - number of busy registers
// Options     : REGFILE_BYPASS_EN  - forward same-cycle write data to reads
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int NREG = DEF_NREG,
    parameter int NRD  = DEF_NRD,
    // Derived from NREG; not meant to be overridden.
    parameter int AW   = addr_width(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rs,
    output logic [NRD*XLEN-1:0] rv,
    output logic [NRD-1:0]      rbusy,
    input  logic                we,
    input  logic [AW-1:0]       rd,
    input  logic [XLEN-1:0]     indata,
    input  logic                issue_en,
    input  logic [AW-1:0]       issue_rd,
    output logic [AW:0]         busy_cnt,
    input  logic                sb_clr
);

    logic [XLEN-1:0] w_regs [NREG];
    logic [NREG-1:0] w_busy;
    logic            w_wr;

    assign w_wr = we && (rd != AW'(ZERO_REG));

    // Register 0 has no storage and reads as zero.
    assign w_regs[ZERO_REG] = '0;

    for (genvar j = 1; j < NREG; j++) begin : g_reg
        logic [XLEN-1:0] r_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_q <= '0;
            end else if (w_wr && (rd == AW'(j))) begin
                r_q <= indata;
            end
        end

        assign w_regs[j] = r_q;
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issue_en),
        .set_idx  (issue_rd),
        .clr_en   (we),
        .clr_idx  (rd),
        .flush    (sb_clr),
        .busy     (w_busy),
        .busy_cnt (busy_cnt)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] w_idx;

        assign w_idx = rs[i*AW +: AW];

`ifdef REGFILE_BYPASS_EN
        // A matching write this cycle forwards its data and hides any busy
        // state, including a same-cycle issue to that register.
        logic w_hit;

        assign w_hit               = w_wr && (w_idx == rd);
        assign rv[i*XLEN +: XLEN]  = w_hit ? indata : w_regs[w_idx];
        assign rbusy[i]            = w_busy[w_idx] & ~w_hit;
`else
        assign rv[i*XLEN +: XLEN]  = w_regs[w_idx];
        assign rbusy[i]            = w_busy[w_idx];
`endif
    end

endmodule : regfile_sb
`default_nettype wire
